hilo_mult_seq: RTL and testbench
================================

Name: hilo_mult_seq

Overview:
Sequencer between the CPU control unit and the 32-cycle Booth multiplier. It captures operands on a MULT request and issues a one-cycle `mult_start`. It waits for the multiplier's `ciclos_end`, then commits `hi`/`lo` into the architectural HI/LO registers and pulses `done`. It also holds the HI/LO pair for MFHI/MFLO, accepts MTHI/MTLO writes, raises `busy` for control-unit stalls, and recovers from a hung multiplier through a timeout.

Parameters:
WIDTH, 32, operand and HI/LO width
TIMEOUT, 40, maximum WAIT-state cycles before abort (must be greater than 33)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low
op_mult  in  1  one-cycle MULT request from control unit
op_mthi  in  1  write wr_data to HI
op_mtlo  in  1  write wr_data to LO
wr_data  in  WIDTH  MTHI/MTLO data
operand_a  in  WIDTH  multiplicand, sampled with op_mult
operand_b  in  WIDTH  multiplier, sampled with op_mult
mult_start  out  1  to multiplier mult_start
mult_outA  out  WIDTH  held operand A to multiplier
mult_outB  out  WIDTH  held operand B to multiplier
mult_reset  out  1  active-high reset to multiplier
mult_hi  in  WIDTH  multiplier hi
mult_lo  in  WIDTH  multiplier lo
mult_ciclos_end  in  1  multiplier completion flag (sticky until next start)
hi_out  out  WIDTH  architectural HI
lo_out  out  WIDTH  architectural LO
busy  out  1  high from cycle after op_mult accept through DONE
done  out  1  one-cycle commit pulse
timeout_err  out  1  sticky hang indicator

Behaviour:
- Reset (`reset`=0 at a clock edge): all registers cleared.
  - hi_out, lo_out, mult_outA, mult_outB are 0.
  - mult_start, busy, done, timeout_err are 0.
  - state is IDLE and wait_cnt is 0.
- `mult_reset` is combinational: !reset | abort_q. It is therefore 1 throughout reset.
- Reset mid-operation aborts immediately; no partial commit.
- State IDLE:
  - op_mult=1: latch operand_a/operand_b, go to START. op_mult has priority over op_mthi/op_mtlo in the same cycle; the MT* request is dropped.
  - Otherwise, op_mthi writes HI and op_mtlo writes LO on the next edge. Both may fire together.
- State START: mult_start=1 for exactly this cycle; wait_cnt cleared. Next state is WAIT.
- State WAIT:
  - wait_cnt increments every edge.
  - mult_ciclos_end is qualified only when wait_cnt ≥ 1, which masks any stale sticky value.
  - Qualified ciclos_end=1: latch mult_hi into HI and mult_lo into LO, go to DONE.
  - Else if wait_cnt == TIMEOUT-1: set timeout_err, abort_q=1 for one cycle, go to IDLE. HI/LO unchanged, no done.
- State DONE: done=1 for one cycle, then IDLE.
- Latency: op_mult sampled at edge E0.
  - mult_start is high E0–E1.
  - Multiplier raises ciclos_end after E33.
  - HI/LO commit at E34; done is high E34–E35.
  - Total 34 cycles.
- busy = (state ≠ IDLE). op_mult, op_mthi and op_mtlo are ignored while busy; the control unit must stall.
- mult_outA/mult_outB are held stable from START until the next accepted op_mult.
- timeout_err is cleared only by reset.
- No arithmetic beyond the wait_cnt increment. wait_cnt width is clog2(TIMEOUT)+1 and it saturates, never wraps.

Decomposition:
- Package muldiv_pkg:
  - state enum {IDLE, START, WAIT, DONE}
  - WIDTH and TIMEOUT defaults
  - wait counter width constant
- Sub-module hilo_regs: HI/LO register pair.
  - Inputs: per-register write enables and data, with sequencer commit taking priority over MT* writes.
  - Synchronous active-low reset to 0.
- Sequencer FSM stays in the top module.

Test Plan:
1. reset=0 for 2 cycles, then 1 -> all outputs 0 during reset; mult_reset=1 during reset and 0 after.
2. op_mult A=7, B=0xFFFFFFFD with real multiplier -> mult_start single cycle; done exactly 34 cycles after request; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; busy drops with IDLE.
3. op_mult A=0x7FFFFFFF, B=0x7FFFFFFF -> hi_out=0x3FFFFFFF, lo_out=0x00000001. Then a second op_mult A=2, B=3 is issued immediately with multiplier ciclos_end still sticky high -> no early commit; lo_out=6, hi_out=0 after 34 cycles.
4. IDLE op_mthi, wr_data=0x12345678 -> hi_out=0x12345678 next cycle. op_mtlo during busy -> lo_out unchanged. op_mult+op_mthi same cycle -> MULT accepted, HI not written by MTHI.
5. Stub multiplier never asserts ciclos_end -> after 40 WAIT cycles timeout_err=1, mult_reset high exactly one cycle, done never pulses, HI/LO unchanged, busy=0.
6. reset=0 at WAIT cycle 10 -> next cycle state IDLE, HI/LO=0, busy=0. Subsequent op_mult 5×5 -> lo_out=25.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the HI/LO multiply sequencer
package muldiv_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int TIMEOUT_DEF = 40;

    // Counter wide enough to hold TIMEOUT-1 with one spare bit for saturation.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout) + 1;
    endfunction

    localparam int WAIT_CNT_W = cnt_width(TIMEOUT_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/hilo_mult_seq_if.sv
// rtl/hilo_mult_seq_if.sv - handshake between the sequencer and the Booth multiplier
interface hilo_mult_seq_if #(
    parameter int WIDTH = 32
);
    logic             mult_start;
    logic [WIDTH-1:0] mult_outA;
    logic [WIDTH-1:0] mult_outB;
    logic             mult_reset;
    logic [WIDTH-1:0] mult_hi;
    logic [WIDTH-1:0] mult_lo;
    logic             mult_ciclos_end;

    modport master (
        output mult_start,
        output mult_outA,
        output mult_outB,
        output mult_reset,
        input  mult_hi,
        input  mult_lo,
        input  mult_ciclos_end
    );

    modport slave (
        input  mult_start,
        input  mult_outA,
        input  mult_outB,
        input  mult_reset,
        output mult_hi,
        output mult_lo,
        output mult_ciclos_end
    );
endinterface

// File: rtl/hilo_regs.sv
// rtl/hilo_regs.sv - architectural HI/LO register pair
module hilo_regs
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             commit,
    input  logic [WIDTH-1:0] commit_hi,
    input  logic [WIDTH-1:0] commit_lo,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // A multiplier commit overrides any MTHI/MTLO write in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            hi <= commit_hi;
            lo <= commit_lo;
        end else begin
            if (hi_we) hi <= wr_data;
            if (lo_we) lo <= wr_data;
        end
    end

endmodule

// File: rtl/hilo_mult_seq.sv
// rtl/hilo_mult_seq.sv - MULT sequencer with HI/LO holding and hang timeout
module hilo_mult_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_mult,
    input  logic             op_mthi,
    input  logic             op_mtlo,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    hilo_mult_seq_if.master  mul,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam int            CW       = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [CW-1:0]    wait_cnt_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic             abort_q;
    logic             timeout_err_q;
    logic             accept;
    logic             commit;
    logic             abort;
    logic             end_qual;
    logic             mt_ok;

    // State register; reset drops any operation in flight without committing.
    always_ff @(posedge clock) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state; ciclos_end is ignored on the first WAIT cycle to mask a stale sticky flag.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        commit   = 1'b0;
        abort    = 1'b0;
        end_qual = mul.mult_ciclos_end && (wait_cnt_q != '0);
        case (state_q)
            IDLE: begin
                if (op_mult) begin
                    accept  = 1'b1;
                    state_d = START;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (end_qual) begin
                    commit  = 1'b1;
                    state_d = DONE;
                end else if (wait_cnt_q == CNT_LAST) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // WAIT cycle counter: cleared in START, saturating increment in WAIT.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else if (state_q == START) begin
            wait_cnt_q <= '0;
        end else if (state_q == WAIT && wait_cnt_q != CNT_MAX) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    // Operands are held for the multiplier until the next accepted MULT.
    always_ff @(posedge clock) begin
        if (!reset) begin
            opa_q <= '0;
            opb_q <= '0;
        end else if (accept) begin
            opa_q <= operand_a;
            opb_q <= operand_b;
        end
    end

    // One-cycle multiplier reset after a timeout, plus the sticky error flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            abort_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            abort_q <= abort;
            if (abort) timeout_err_q <= 1'b1;
        end
    end

    // MT* writes only land when idle and not shadowed by a MULT request.
    assign mt_ok = (state_q == IDLE) && !op_mult;

    hilo_regs #(
        .WIDTH (WIDTH)
    ) u_regs (
        .clock     (clock),
        .reset     (reset),
        .commit    (commit),
        .commit_hi (mul.mult_hi),
        .commit_lo (mul.mult_lo),
        .hi_we     (mt_ok && op_mthi),
        .lo_we     (mt_ok && op_mtlo),
        .wr_data   (wr_data),
        .hi        (hi_out),
        .lo        (lo_out)
    );

    assign mul.mult_start = (state_q == START);
    assign mul.mult_outA  = opa_q;
    assign mul.mult_outB  = opb_q;
    assign mul.mult_reset = !reset || abort_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_hilo_mult_seq.sv
// tb/tb_hilo_mult_seq.sv - self-checking bench for hilo_mult_seq
module tb_hilo_mult_seq;

    localparam int W  = 32;
    localparam int TO = 40;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         op_mult = 1'b0;
    logic         op_mthi = 1'b0;
    logic         op_mtlo = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;
    logic         busy;
    logic         done;
    logic         timeout_err;

    int errors = 0;
    int checks = 0;

    hilo_mult_seq_if #(.WIDTH(W)) mif ();

    hilo_mult_seq #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .op_mult     (op_mult),
        .op_mthi     (op_mthi),
        .op_mtlo     (op_mtlo),
        .wr_data     (wr_data),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .mul         (mif.master),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Multiplier stand-in: result appears stub_lat edges after it samples mult_start.
    int           stub_lat = 32;
    bit           stub_lag = 1'b0;
    logic         s_run = 1'b0;
    logic         s_clr = 1'b0;
    logic         s_ce = 1'b0;
    int           s_cnt = 0;
    logic [63:0]  s_prod = '0;
    logic [W-1:0] s_hi = '0;
    logic [W-1:0] s_lo = '0;

    assign mif.mult_hi         = s_hi;
    assign mif.mult_lo         = s_lo;
    assign mif.mult_ciclos_end = s_ce;

    always @(posedge clock) begin
        if (mif.mult_reset) begin
            s_run <= 1'b0;
            s_clr <= 1'b0;
            s_ce  <= 1'b0;
            s_cnt <= 0;
        end else if (mif.mult_start) begin
            s_run  <= 1'b1;
            s_cnt  <= 0;
            s_prod <= prod(mif.mult_outA, mif.mult_outB);
            if (stub_lag) s_clr <= 1'b1;
            else          s_ce  <= 1'b0;
        end else if (s_run) begin
            if (s_clr) begin
                s_ce  <= 1'b0;
                s_clr <= 1'b0;
            end
            s_cnt <= s_cnt + 1;
            if (s_cnt + 1 == stub_lat) begin
                s_ce  <= 1'b1;
                s_hi  <= s_prod[63:32];
                s_lo  <= s_prod[31:0];
                s_run <= 1'b0;
            end
        end
    end

    // Reference: an accepted MULT lives for a number of cycles set by the multiplier latency.
    bit           m_valid = 1'b0;
    bit           m_active = 1'b0;
    bit           m_abort = 1'b0;
    bit           m_terr = 1'b0;
    int           m_age = 0;
    int           m_lat = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [63:0]  m_p;

    always @(posedge clock) begin
        m_valid = 1'b1;
        if (!reset) begin
            m_active = 1'b0; m_abort = 1'b0; m_terr = 1'b0; m_age = 0;
            m_a = '0; m_b = '0; m_hi = '0; m_lo = '0;
        end else begin
            m_abort = 1'b0;
            if (!m_active) begin
                if (op_mult) begin
                    m_active = 1'b1; m_age = 0; m_lat = stub_lat;
                    m_a = operand_a; m_b = operand_b;
                end else begin
                    if (op_mthi) m_hi = wr_data;
                    if (op_mtlo) m_lo = wr_data;
                end
            end else begin
                m_age++;
                if (m_lat < TO && m_age == m_lat + 2) begin
                    m_p = prod(m_a, m_b);
                    m_hi = m_p[63:32];
                    m_lo = m_p[31:0];
                end else if (m_lat < TO && m_age == m_lat + 3) begin
                    m_active = 1'b0;
                end else if (m_lat >= TO && m_age == TO + 1) begin
                    m_active = 1'b0; m_terr = 1'b1; m_abort = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the reference.
    always @(negedge clock) begin
        if (m_valid) begin
            check("busy", busy, m_active);
            check("done", done, m_active && m_lat < TO && m_age == m_lat + 2);
            check("mult_start", mif.mult_start, m_active && m_age == 0);
            check("mult_reset", mif.mult_reset, !reset || m_abort);
            check("timeout_err", timeout_err, m_terr);
            check("hi_out", hi_out, m_hi);
            check("lo_out", lo_out, m_lo);
            check("mult_outA", mif.mult_outA, m_a);
            check("mult_outB", mif.mult_outB, m_b);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        tick();
    endtask

    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, output int n);
        operand_a = a;
        operand_b = b;
        op_mult   = 1'b1;
        tick();
        op_mult   = 1'b0;
        wait_done(n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int rcnt;
        int dcnt;
        int first_idle;
        int lat;
        int r;

        tick();
        tick();
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_start", mif.mult_start, 0);
        check("rst_mreset", mif.mult_reset, 1);
        reset = 1'b1;
        #1;
        check("post_rst_mreset", mif.mult_reset, 0);
        tick();

        stub_lat = 32;
        run_mult(32'd7, 32'hFFFF_FFFD, n);
        check("lat_7x-3", n, 34);
        check("hi_7x-3", hi_out, 64'h0000_0000_FFFF_FFFF);
        check("lo_7x-3", lo_out, 64'h0000_0000_FFFF_FFEB);
        check("busy_after", busy, 0);

        stub_lag = 1'b1;
        run_mult(32'h7FFF_FFFF, 32'h7FFF_FFFF, n);
        check("hi_max", hi_out, 64'h3FFF_FFFF);
        check("lo_max", lo_out, 64'h1);
        run_mult(32'd2, 32'd3, n);
        check("lat_sticky", n, 34);
        check("lo_2x3", lo_out, 64'd6);
        check("hi_2x3", hi_out, 64'd0);
        stub_lag = 1'b0;

        wr_data = 32'h1234_5678;
        op_mthi = 1'b1;
        tick();
        op_mthi = 1'b0;
        check("mthi", hi_out, 64'h1234_5678);
        operand_a = 32'd5;
        operand_b = 32'd6;
        wr_data   = 32'hDEAD_BEEF;
        op_mult   = 1'b1;
        op_mthi   = 1'b1;
        tick();
        op_mult = 1'b0;
        op_mthi = 1'b0;
        check("mult_over_mthi", hi_out, 64'h1234_5678);
        check("mult_accepted", busy, 1);
        tick();
        tick();
        wr_data = 32'hCAFE_F00D;
        op_mtlo = 1'b1;
        tick();
        op_mtlo = 1'b0;
        check("mtlo_busy", lo_out, 64'd6);
        wait_done(n);
        check("hi_5x6", hi_out, 64'd0);
        check("lo_5x6", lo_out, 64'd30);

        stub_lat  = 1000;
        operand_a = 32'd9;
        operand_b = 32'd9;
        op_mult   = 1'b1;
        tick();
        op_mult    = 1'b0;
        rcnt       = 0;
        dcnt       = 0;
        first_idle = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (done) dcnt++;
            if (mif.mult_reset) rcnt++;
            if (!busy && first_idle < 0) first_idle = i;
        end
        check("to_err", timeout_err, 1);
        check("to_idle_cycle", first_idle, 40);
        check("to_mreset_cycles", rcnt, 1);
        check("to_no_done", dcnt, 0);
        check("to_hi", hi_out, 64'd0);
        check("to_lo", lo_out, 64'd30);

        stub_lat  = 32;
        operand_a = 32'd3;
        operand_b = 32'd4;
        op_mult   = 1'b1;
        tick();
        op_mult = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_hi", hi_out, 0);
        check("mid_rst_lo", lo_out, 0);
        check("mid_rst_terr", timeout_err, 0);
        run_mult(32'd5, 32'd5, n);
        check("lat_5x5", n, 34);
        check("lo_5x5", lo_out, 64'd25);

        for (int it = 0; it < 60; it++) begin
            wr_data = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                op_mthi = 1'($urandom_range(0, 1));
                op_mtlo = 1'($urandom_range(0, 1));
                tick();
                op_mthi = 1'b0;
                op_mtlo = 1'b0;
            end else begin
                r = $urandom_range(0, 9);
                if (r == 0)      lat = TO - 1;
                else if (r == 1) lat = TO;
                else if (r == 2) lat = 1;
                else             lat = $urandom_range(2, 45);
                stub_lat  = lat;
                stub_lag  = 1'($urandom_range(0, 1));
                operand_a = $urandom;
                operand_b = $urandom;
                op_mult   = 1'b1;
                op_mthi   = 1'($urandom_range(0, 1));
                tick();
                op_mult = 1'b0;
                for (int c = 0; c < 50; c++) begin
                    op_mthi = ($urandom_range(0, 7) == 0);
                    op_mtlo = ($urandom_range(0, 7) == 0);
                    wr_data = $urandom;
                    tick();
                    if (!busy) break;
                end
                op_mthi = 1'b0;
                op_mtlo = 1'b0;
                check("rand_idle", busy, 0);
            end
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
